challenge_encrypt_tx: RTL
=========================

// Module: challenge_encrypt_tx
// PURPOSE
//  Transmit side of the challenge/response check. Latches a 32-bit challenge
//  r and a 4-bit shared key k on start. Emits the ciphertext c = r ^ k as
//  eight 4-bit nibbles, LSB nibble first, over a valid/ready stream.
//  The far-end checker XORs each nibble with k and compares against r.
// PARAMETERS
//  DATA_W   32  challenge width, in bits; must be a multiple of NIB_W
//  NIB_W    4   nibble/key width, in bits
//  NUM_NIB  8   DATA_W/NIB_W, nibbles per frame (derived localparam)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  start_i    in   1       request a frame; sampled only in IDLE
//  r_i        in   DATA_W  challenge word, latched when start_i is accepted
//  k_i        in   NIB_W   shared key nibble, latched when start_i is accepted
//  c_valid_o  out  1       c_data_o holds a valid nibble
//  c_ready_i  in   1       sink accepts the nibble this cycle
//  c_data_o   out  NIB_W   ciphertext nibble = r_lat[4*i+3:4*i] ^ k_lat
//  c_last_o   out  1       high with the final nibble (i = NUM_NIB-1)
//  busy_o     out  1       high in SEND and DONE
//  done_o     out  1       one-cycle pulse after the last nibble transfers
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (rst=0) clears all outputs, the nibble index and the latches to 0,
//    and forces the FSM to IDLE. This holds at any point, including mid-frame.
//    Any partial frame is abandoned and is not resumed after reset.
//  - FSM states are IDLE, SEND and DONE.
//  - IDLE: c_valid_o=0 and busy_o=0.
//    start_i=1 latches r_i and k_i, sets index i=0, and moves to SEND.
//  - Latency: start accepted at edge N -> c_valid_o=1 with nibble 0 after N.
//  - SEND: c_valid_o=1. A transfer occurs on an edge where c_valid_o and
//    c_ready_i are both 1.
//  - On a transfer with i<NUM_NIB-1: i increments and the next nibble is
//    driven after that edge.
//  - c_valid_o=1 with c_ready_i=0: c_data_o and c_last_o hold stable. There
//    is no timeout.
//  - On the transfer of nibble NUM_NIB-1 (c_last_o=1): move to DONE.
//    c_valid_o and c_last_o drop to 0 and done_o goes to 1.
//  - DONE lasts exactly one cycle (done_o=1, busy_o=1), then returns to IDLE.
//  - start_i is ignored in SEND and DONE. The earliest re-accept is the IDLE
//    cycle that follows DONE.
//  - r_i and k_i changes after acceptance have no effect on the frame in
//    flight.
//  - Minimum frame time with ready held high: 1 (accept) + 8 (SEND) + 1
//    (DONE) = 10 cycles from start_i to the next IDLE.
//  - The XOR is bitwise, with no carry. Nibble i uses bits
//    [NIB_W*i+NIB_W-1 : NIB_W*i].
// TESTING
//  1. r=0x12345678, k=0xA, ready=1: nibbles 2,D,C,F,E,9,8,B. c_last_o is
//     high on the B nibble only, and done_o pulses on the next cycle.
//  2. k=0x0, r=0xDEADBEEF: nibbles F,E,E,B,D,A,E,D, which equal r's
//     nibbles LSB-first.
//  3. Backpressure: ready low for 3 cycles on nibble 4.
//     -> c_data_o=0xE is held stable, no nibble is skipped or duplicated,
//     and the frame completes with 8 transfers.
//  4. start_i pulsed in SEND with a new r and k -> ignored; the frame
//     finishes using the original values.
//  5. rst asserted after 3 transfers -> all outputs read 0 immediately.
//     After release, a new start sends a full 8-nibble frame from nibble 0.
//  6. Loopback: 100 random (r,k) pairs, with random ready, are reassembled
//     and XORed with k. The result must equal r every time, and exactly one
//     done_o pulse must occur per frame.

Source files
------------

// File: rtl/challenge_encrypt_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | challenge_encrypt_tx_if : start request + ciphertext nibble stream   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface challenge_encrypt_tx_if #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
);
  logic              start_i;
  logic [DATA_W-1:0] r_i;
  logic [NIB_W-1:0]  k_i;
  logic              c_valid_o;
  logic              c_ready_i;
  logic [NIB_W-1:0]  c_data_o;
  logic              c_last_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, r_i, k_i, c_ready_i,
    output c_valid_o, c_data_o, c_last_o, busy_o, done_o
  );

  modport slave (
    output start_i, r_i, k_i, c_ready_i,
    input  c_valid_o, c_data_o, c_last_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/challenge_encrypt_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | challenge_encrypt_tx : sends (r ^ k) as LSB-first nibbles on a       |
// | valid/ready stream.                                       Rev 1.0    |
// +----------------------------------------------------------------------+
module challenge_encrypt_tx #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  challenge_encrypt_tx_if.master  bus
);
  localparam int NUM_NIB = DATA_W / NIB_W;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [DATA_W-1:0] r_lat_q,   r_lat_d;
  logic [NIB_W-1:0]  k_lat_q,   k_lat_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              c_valid_q, c_valid_d;
  logic [NIB_W-1:0]  c_data_q,  c_data_d;
  logic              c_last_q,  c_last_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic              w_xfer;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [NIB_W-1:0]  w_nib_nxt;

  always_comb begin
    state_d   = state_q;
    r_lat_d   = r_lat_q;
    k_lat_d   = k_lat_q;
    idx_d     = idx_q;
    c_valid_d = c_valid_q;
    c_data_d  = c_data_q;
    c_last_d  = c_last_q;
    busy_d    = busy_q;
    done_d    = done_q;

    w_xfer    = c_valid_q & bus.c_ready_i;
    w_idx_nxt = idx_q + IDX_W'(1);
    // Outputs are registered, so the next nibble is prepared one edge ahead.
    w_nib_nxt = r_lat_q[NIB_W*w_idx_nxt +: NIB_W] ^ k_lat_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          r_lat_d   = bus.r_i;
          k_lat_d   = bus.k_i;
          idx_d     = '0;
          c_valid_d = 1'b1;
          c_data_d  = bus.r_i[NIB_W-1:0] ^ bus.k_i;
          c_last_d  = (LAST_IDX == '0);
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (idx_q == LAST_IDX) begin
            c_valid_d = 1'b0;
            c_last_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            idx_d    = w_idx_nxt;
            c_data_d = w_nib_nxt;
            c_last_d = (w_idx_nxt == LAST_IDX);
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        c_valid_d = 1'b0;
        c_last_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      r_lat_q   <= '0;
      k_lat_q   <= '0;
      idx_q     <= '0;
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
      c_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_lat_q   <= r_lat_d;
      k_lat_q   <= k_lat_d;
      idx_q     <= idx_d;
      c_valid_q <= c_valid_d;
      c_data_q  <= c_data_d;
      c_last_q  <= c_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.c_valid_o = c_valid_q;
  assign bus.c_data_o  = c_data_q;
  assign bus.c_last_o  = c_last_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
endmodule
`default_nettype wire
